// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state encoding, port indices and one-hot helpers for the read arbiter
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_TIMEOUT = 2'd3
    } arb_state_e;

    localparam int         NUM_PORTS = 3;
    localparam logic [1:0] PORT_0    = 2'd0;
    localparam logic [1:0] PORT_1    = 2'd1;
    localparam logic [1:0] PORT_2    = 2'd2;
    localparam logic [1:0] PORT_NONE = 2'b11;

    function automatic logic [2:0] port_onehot(input logic [1:0] port);
        case (port)
            PORT_0:  return 3'b001;
            PORT_1:  return 3'b010;
            PORT_2:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] onehot_port(input logic [2:0] oh);
        if (oh[0])      return PORT_0;
        else if (oh[1]) return PORT_1;
        else if (oh[2]) return PORT_2;
        else            return PORT_NONE;
    endfunction

endpackage

// File: rtl/router_rd_arbiter_if.sv
// rtl/router_rd_arbiter_if.sv - FIFO-side and consumer-side signals of the read arbiter
interface router_rd_arbiter_if #(
    parameter int DW = 8
);
    logic          fifo_empty_0;
    logic          fifo_empty_1;
    logic          fifo_empty_2;
    logic [DW-1:0] data_out_0;
    logic [DW-1:0] data_out_1;
    logic [DW-1:0] data_out_2;
    logic          dout_ready;
    logic          read_enb_0;
    logic          read_enb_1;
    logic          read_enb_2;
    logic          soft_reset_0;
    logic          soft_reset_1;
    logic          soft_reset_2;
    logic [DW-1:0] data_out;
    logic          vld_out;
    logic [1:0]    grant;
    logic          arb_busy;

    modport master (
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  data_out_0, data_out_1, data_out_2,
        input  dout_ready,
        output read_enb_0, read_enb_1, read_enb_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output data_out, vld_out, grant, arb_busy
    );

    modport slave (
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output data_out_0, data_out_1, data_out_2,
        output dout_ready,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  data_out, vld_out, grant, arb_busy
    );
endinterface

// File: rtl/router_rr_pick.sv
// rtl/router_rr_pick.sv - combinational round-robin pick of the first requester after last_grant
module router_rr_pick
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] grant
);

    logic [1:0] idx;

    // Scan farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant = PORT_NONE;
        idx   = PORT_0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = 2'((int'(last_grant) + i) % NUM_PORTS);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/router_rd_arbiter.sv
// rtl/router_rd_arbiter.sv - packet-granular round-robin read arbiter over three destination FIFOs
module router_rd_arbiter
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int DW      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    router_rd_arbiter_if.master  bus
);

    localparam logic [4:0] STALL_LAST = 5'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    last_grant_q, last_grant_d;
    logic [1:0]    sel_q, sel_d;
    logic [4:0]    stall_q, stall_d;
    logic          vld_q, vld_d;

    logic [2:0]    empty_v;
    logic [2:0]    req_v;
    logic [1:0]    pick;
    logic          empty_g;
    logic [2:0]    rd_en;
    logic [2:0]    soft_rst;
    logic [DW-1:0] data_mux;

    assign empty_v = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign req_v   = ~empty_v;
    assign empty_g = |(empty_v & port_onehot(grant_q));

    router_rr_pick u_rr_pick (
        .req        (req_v),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= PORT_NONE;
            last_grant_q <= PORT_2;
            sel_q        <= PORT_NONE;
            stall_q      <= '0;
            vld_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            stall_q      <= stall_d;
            vld_q        <= vld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_d      = stall_q;
        vld_d        = |rd_en;
        sel_d        = onehot_port(rd_en);
        case (state_q)
            ST_IDLE: begin
                if (|req_v) begin
                    state_d = ST_READ;
                    grant_d = pick;
                end
            end
            ST_READ: begin
                // Empty wins over a stall that would otherwise expire this cycle.
                if (empty_g) begin
                    state_d = ST_DRAIN;
                    stall_d = '0;
                end else if (bus.dout_ready) begin
                    stall_d = '0;
                end else if (stall_q == STALL_LAST) begin
                    state_d = ST_TIMEOUT;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + 5'd1;
                end
            end
            ST_DRAIN, ST_TIMEOUT: begin
                state_d      = ST_IDLE;
                last_grant_d = grant_q;
                grant_d      = PORT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = PORT_NONE;
            end
        endcase
    end

    always_comb begin
        rd_en    = '0;
        soft_rst = '0;
        if (state_q == ST_READ && bus.dout_ready && !empty_g) begin
            rd_en = port_onehot(grant_q);
        end
        if (state_q == ST_TIMEOUT) begin
            soft_rst = port_onehot(grant_q);
        end
        // FIFO read data lands one cycle after its strobe, so steer by last cycle's reader.
        case (sel_q)
            PORT_0:  data_mux = bus.data_out_0;
            PORT_1:  data_mux = bus.data_out_1;
            PORT_2:  data_mux = bus.data_out_2;
            default: data_mux = '0;
        endcase
    end

    assign bus.read_enb_0   = rd_en[0];
    assign bus.read_enb_1   = rd_en[1];
    assign bus.read_enb_2   = rd_en[2];
    assign bus.soft_reset_0 = soft_rst[0];
    assign bus.soft_reset_1 = soft_rst[1];
    assign bus.soft_reset_2 = soft_rst[2];
    assign bus.data_out     = data_mux;
    assign bus.vld_out      = vld_q;
    assign bus.grant        = grant_q;
    assign bus.arb_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_router_rd_arbiter.sv
// tb/tb_router_rd_arbiter.sv - directed bench with FIFO environment and behavioural arbiter model
module tb_router_rd_arbiter;

    localparam int DW = 8;
    localparam int TO = 30;
    localparam int M_IDLE = 0, M_READ = 1, M_CLOSE = 2, M_EXPIRE = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    router_rd_arbiter_if #(.DW(DW)) bus ();

    router_rd_arbiter #(.TIMEOUT(TO), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] q [3][$];
    logic [7:0] rdata [3];

    int         m_mode, m_owner, m_last, m_stall, m_prev_port;
    logic [7:0] m_prev_byte;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         n_rd [3];
    int         n_sr [3];
    int         n_vld, sr_cyc, first_g_cyc, rd_first, vld_first;
    logic [1:0] prev_g;
    int         gseq [$];
    logic [7:0] vbytes [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void sync_inputs();
        bus.fifo_empty_0 = (q[0].size() == 0);
        bus.fifo_empty_1 = (q[1].size() == 0);
        bus.fifo_empty_2 = (q[2].size() == 0);
        bus.data_out_0   = rdata[0];
        bus.data_out_1   = rdata[1];
        bus.data_out_2   = rdata[2];
    endfunction

    function automatic void model_init();
        m_mode      = M_IDLE;
        m_owner     = 0;
        m_last      = 2;
        m_stall     = 0;
        m_prev_port = -1;
        m_prev_byte = '0;
    endfunction

    function automatic void clear_stats();
        for (int p = 0; p < 3; p++) begin
            n_rd[p] = 0;
            n_sr[p] = 0;
        end
        n_vld = 0; sr_cyc = -1; first_g_cyc = -1; rd_first = -1; vld_first = -1;
        prev_g = 2'b11;
        gseq.delete();
        vbytes.delete();
    endfunction

    function automatic int seq_code();
        int c = 0;
        foreach (gseq[i]) c = c * 10 + gseq[i] + 1;
        return c;
    endfunction

    function automatic logic [31:0] vb_code();
        logic [31:0] c = '0;
        foreach (vbytes[i]) c = (c << 8) | 32'(vbytes[i]);
        return c;
    endfunction

    task automatic tick();
        logic [2:0]  rd, sr, e_rd, e_sr;
        logic [1:0]  e_grant;
        logic        e_vld;
        logic [7:0]  e_data;
        logic [17:0] e_vec, a_vec;
        @(negedge clock);
        e_rd = '0;
        e_sr = '0;
        if (m_mode == M_READ && bus.dout_ready && q[m_owner].size() > 0) e_rd[m_owner] = 1'b1;
        if (m_mode == M_EXPIRE) e_sr[m_owner] = 1'b1;
        e_grant = (m_mode == M_IDLE) ? 2'b11 : 2'(m_owner);
        e_vld   = (m_prev_port >= 0);
        e_data  = e_vld ? m_prev_byte : 8'h00;
        rd = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
        sr = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
        e_vec = {(m_mode != M_IDLE), e_grant, e_rd, e_sr, e_vld, e_data};
        a_vec = {bus.arb_busy, bus.grant, rd, sr, bus.vld_out, bus.data_out};
        chk("cycle", 32'(a_vec), 32'(e_vec));

        for (int p = 0; p < 3; p++) begin
            n_rd[p] += int'(rd[p]);
            n_sr[p] += int'(sr[p]);
            if (sr[p]) sr_cyc = cyc;
        end
        if (bus.vld_out) begin
            n_vld++;
            vbytes.push_back(bus.data_out);
            if (vld_first < 0) vld_first = cyc;
        end
        if (rd != 3'b000 && rd_first < 0) rd_first = cyc;
        if (bus.grant != 2'b11 && bus.grant != prev_g) begin
            if (gseq.size() == 0) first_g_cyc = cyc;
            gseq.push_back(int'(bus.grant));
        end
        prev_g = bus.grant;

        if (e_rd != 3'b000) begin
            m_prev_port = m_owner;
            m_prev_byte = q[m_owner][0];
        end else begin
            m_prev_port = -1;
        end
        case (m_mode)
            M_IDLE: begin
                m_stall = 0;
                for (int k = 3; k >= 1; k--) begin
                    if (q[(m_last + k) % 3].size() > 0) begin
                        m_owner = (m_last + k) % 3;
                        m_mode  = M_READ;
                    end
                end
            end
            M_READ: begin
                if (q[m_owner].size() == 0) m_mode = M_CLOSE;
                else if (bus.dout_ready) m_stall = 0;
                else begin
                    m_stall++;
                    if (m_stall == TO) m_mode = M_EXPIRE;
                end
            end
            default: begin
                m_last = m_owner;
                m_mode = M_IDLE;
            end
        endcase

        @(posedge clock);
        #1;
        for (int p = 0; p < 3; p++) begin
            if (rd[p] && q[p].size() > 0) rdata[p] = q[p].pop_front();
            if (sr[p]) q[p].delete();
        end
        sync_inputs();
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'h3);
        chk({tag, "_busy"}, 32'(bus.arb_busy), 32'h0);
        chk({tag, "_vld"}, 32'(bus.vld_out), 32'h0);
        chk({tag, "_data"}, 32'(bus.data_out), 32'h0);
        chk({tag, "_rd"}, 32'({bus.read_enb_2, bus.read_enb_1, bus.read_enb_0}), 32'h0);
        chk({tag, "_sr"}, 32'({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}), 32'h0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_init();
    endtask

    initial begin
        for (int p = 0; p < 3; p++) rdata[p] = '0;
        bus.dout_ready = 1'b0;
        sync_inputs();
        model_init();
        clear_stats();

        // Reset state
        @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // Single port, 4-byte packet
        q[1] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        sync_inputs();
        bus.dout_ready = 1'b1;
        repeat (10) tick();
        chk("single_seq", 32'(seq_code()), 32'd2);
        chk("single_rd1", 32'(n_rd[1]), 32'd4);
        chk("single_vld", 32'(n_vld), 32'd4);
        chk("single_bytes", vb_code(), 32'hA1A2A3A4);
        chk("single_latency", 32'(vld_first - rd_first), 32'd1);
        chk("single_idle", 32'(bus.arb_busy), 32'h0);

        // Round robin from reset: 0,1,2 then again after refill
        pulse_reset();
        clear_stats();
        q[0] = '{8'h10, 8'h11};
        q[1] = '{8'h20};
        q[2] = '{8'h30, 8'h31, 8'h32};
        sync_inputs();
        repeat (25) tick();
        chk("rr_seq1", 32'(seq_code()), 32'd123);
        chk("rr_vld1", 32'(n_vld), 32'd6);
        q[0] = '{8'h12};
        q[1] = '{8'h21};
        q[2] = '{8'h33};
        sync_inputs();
        repeat (20) tick();
        chk("rr_seq2", 32'(seq_code()), 32'd123123);

        // Stall timeout on port 0, then port 1 served
        clear_stats();
        bus.dout_ready = 1'b0;
        q[0] = '{8'h40, 8'h41, 8'h42};
        q[1] = '{8'h50, 8'h51};
        sync_inputs();
        repeat (32) tick();
        chk("to_sr0_width", 32'(n_sr[0]), 32'd1);
        chk("to_sr0_cycle", 32'(sr_cyc - first_g_cyc), 32'd30);
        chk("to_rd0", 32'(n_rd[0]), 32'd0);
        bus.dout_ready = 1'b1;
        repeat (10) tick();
        chk("to_seq", 32'(seq_code()), 32'd12);
        chk("to_rd1", 32'(n_rd[1]), 32'd2);
        chk("to_sr1", 32'(n_sr[1]), 32'd0);

        // 29 stalled cycles twice, never expiring
        clear_stats();
        bus.dout_ready = 1'b0;
        q[2] = '{8'h3C, 8'h3D};
        sync_inputs();
        tick();
        repeat (29) tick();
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        repeat (29) tick();
        bus.dout_ready = 1'b1;
        repeat (6) tick();
        chk("st29_sr", 32'(n_sr[0] + n_sr[1] + n_sr[2]), 32'd0);
        chk("st29_rd2", 32'(n_rd[2]), 32'd2);
        chk("st29_bytes", vb_code(), 32'h00003C3D);

        // Empty on the cycle the stall would expire: drain wins
        clear_stats();
        bus.dout_ready = 1'b0;
        q[0] = '{8'h70};
        sync_inputs();
        tick();
        repeat (29) tick();
        q[0].delete();
        sync_inputs();
        repeat (5) tick();
        chk("race_sr", 32'(n_sr[0] + n_sr[1] + n_sr[2]), 32'd0);
        chk("race_seq", 32'(seq_code()), 32'd1);
        chk("race_idle", 32'(bus.arb_busy), 32'h0);

        // Reset mid-READ of port 2, then port 0 wins
        clear_stats();
        bus.dout_ready = 1'b1;
        q[2] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
        sync_inputs();
        repeat (3) tick();
        chk("mid_grant2", 32'(seq_code()), 32'd3);
        q[0] = '{8'h90};
        q[1] = '{8'h91};
        sync_inputs();
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_init();
        clear_stats();
        repeat (30) tick();
        chk("mid_seq", 32'(seq_code()), 32'd123);
        chk("mid_vld", 32'(n_vld), 32'd5);
        chk("mid_sr", 32'(n_sr[0] + n_sr[1] + n_sr[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
